mult_arbiter: RTL and testbench

Round-robin scheduler that shares one sequential shift-add multiplier between `NUM_REQ` requesters. It accepts operand pairs from the requesters and grants one at a time. It starts the multiplier with a one-cycle pulse, waits for the multiplier's Ready pulse, and returns the product to the granted requester with a one-cycle Done strobe. It sits between the client logic and the multiplier's controller/datapath pair, and is the only block that drives the multiplier's Start and operand inputs.

---
 rtl/mult_arb_pkg.sv | 21 ++
 rtl/mult_arb_rr_pick.sv | 30 +++
 rtl/mult_arbiter.sv | 136 +++++++++++++
 tb/tb_mult_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state type, index-width helper and default
// parameters for the shared-multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/mult_arb_rr_pick.sv
// mult_arb_rr_pick: combinational round-robin picker. Finds the first
// asserted request searching upward from (Last+1) mod NUM_REQ with wrap.
module mult_arb_rr_pick
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [IDX_W-1:0]   Last,
    output logic               Any,
    output logic [IDX_W-1:0]   Idx
);

    logic [IDX_W-1:0] cand_idx;

    // Scan farthest-to-nearest so the nearest candidate after Last wins.
    always_comb begin
        Any      = |Req;
        Idx      = '0;
        cand_idx = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand_idx = IDX_W'((32'(Last) + k) % NUM_REQ);
            if (Req[cand_idx]) begin
                Idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin scheduler sharing one sequential multiplier
// between NUM_REQ requesters. Optional macro MULT_ARB_TIMEOUT_EN bounds
// the WAIT state to TIMEOUT cycles and reports expiry on Error.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            Req,
    input  logic [NUM_REQ*WIDTH-1:0]      Op_A,
    input  logic [NUM_REQ*WIDTH-1:0]      Op_B,
    output logic [NUM_REQ-1:0]            Done,
    output logic [2*WIDTH-1:0]            Result,
    output logic                          Error,
    output logic                          Busy,
    output logic [idx_width(NUM_REQ)-1:0] Grant_Id,
    output logic                          Mult_Start,
    output logic [WIDTH-1:0]              Mult_A,
    output logic [WIDTH-1:0]              Mult_B,
    input  logic                          Mult_Ready,
    input  logic [2*WIDTH-1:0]            Mult_Product
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT < 2) begin : g_bad_cfg
        $error("mult_arbiter: NUM_REQ and TIMEOUT must both be at least 2");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = idx_width(TIMEOUT);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign Error = 1'b0;
`endif

    mult_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .Req  (Req),
        .Last (last),
        .Any  (pick_any),
        .Idx  (pick_idx)
    );

    // Operand slices of the requester the picker has chosen.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_a = Op_A[i*WIDTH +: WIDTH];
                sel_b = Op_B[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control FSM; every output is registered on the state transition.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            last       <= IDX_W'(NUM_REQ - 1);
            Done       <= '0;
            Result     <= '0;
            Busy       <= 1'b0;
            Grant_Id   <= '0;
            Mult_Start <= 1'b0;
            Mult_A     <= '0;
            Mult_B     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            Error      <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        Mult_A     <= sel_a;
                        Mult_B     <= sel_b;
                        Grant_Id   <= pick_idx;
                        Mult_Start <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    Mult_Start <= 1'b0;
                    state      <= ST_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (Mult_Ready) begin
                        Result         <= Mult_Product;
                        Done[Grant_Id] <= 1'b1;
                        state          <= ST_DONE;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        Result         <= '0;
                        Error          <= 1'b1;
                        Done[Grant_Id] <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    Done  <= '0;
                    Busy  <= 1'b0;
                    last  <= Grant_Id;
                    state <= ST_IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
                    Error <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: table vectors, hand sequences and randomized traffic
// checked against a transaction-level round-robin model.
module tb_mult_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 64;

    logic           Clock;
    logic           Reset;
    logic [N-1:0]   Req;
    logic [N*W-1:0] Op_A;
    logic [N*W-1:0] Op_B;
    logic [N-1:0]   Done;
    logic [2*W-1:0] Result;
    logic           Error;
    logic           Busy;
    logic [1:0]     Grant_Id;
    logic           Mult_Start;
    logic [W-1:0]   Mult_A;
    logic [W-1:0]   Mult_B;
    logic           Mult_Ready;
    logic [2*W-1:0] Mult_Product;

    mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Req          (Req),
        .Op_A         (Op_A),
        .Op_B         (Op_B),
        .Done         (Done),
        .Result       (Result),
        .Error        (Error),
        .Busy         (Busy),
        .Grant_Id     (Grant_Id),
        .Mult_Start   (Mult_Start),
        .Mult_A       (Mult_A),
        .Mult_B       (Mult_B),
        .Mult_Ready   (Mult_Ready),
        .Mult_Product (Mult_Product)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int unsigned    n_checks = 0;
    int unsigned    n_fail   = 0;
    int unsigned    cyc      = 0;
    logic [W-1:0]   opa [N];
    logic [W-1:0]   opb [N];
    int unsigned    m_last, m_gid, start_cyc, exp_done_cyc, mcnt;
    int unsigned    fixed_lat, done_id, done_cyc, start_pulses;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] exp_prod, m_result, mprod;
    logic           inflight, prev_busy, timed_out, done_seen;
    logic           rand_lat, spurious_en;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        int unsigned    lat;
        int unsigned    exp_id;
        logic [2*W-1:0] exp_res;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Reference arbitration: first active requester after the last served one.
    function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned last);
        for (int unsigned k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic pack_ops();
        for (int unsigned i = 0; i < N; i++) begin
            Op_A[i*W +: W] = opa[i];
            Op_B[i*W +: W] = opb[i];
        end
    endtask

    // Multiplier stand-in: Ready pulses 'lat' cycles after the start cycle.
    task automatic mult_step();
        Mult_Ready   = 1'b0;
        Mult_Product = 16'($urandom);
        if (Reset === 1'b0) begin
            mcnt = 0;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                Mult_Ready   = 1'b1;
                Mult_Product = mprod;
            end
        end else if (spurious_en && !inflight && $urandom_range(0, 7) == 0) begin
            Mult_Ready = 1'b1;
        end
    endtask

    task automatic monitor();
        logic        exp_start, busy_now, exp_done_now;
        int unsigned g, lat;
        if (Reset === 1'b0) begin
            check("reset_outputs",
                  {Done, Result, Error, Busy, Grant_Id, Mult_Start, Mult_A, Mult_B}, 64'd0);
            inflight  = 1'b0;
            prev_busy = 1'b0;
            timed_out = 1'b0;
            m_last    = N - 1;
            m_gid     = 0;
            m_a       = '0;
            m_b       = '0;
            m_result  = '0;
            return;
        end
        exp_start = !prev_busy && (Req != '0);
        check("mult_start", Mult_Start, exp_start);
        if (Mult_Start === 1'b1) start_pulses++;
        if (exp_start) begin
            g         = rr_pick(Req, m_last);
            m_gid     = g;
            m_a       = opa[g];
            m_b       = opb[g];
            exp_prod  = 16'(m_a) * 16'(m_b);
            inflight  = 1'b1;
            start_cyc = cyc;
            lat       = rand_lat ? $urandom_range(1, 6) : fixed_lat;
            mcnt      = lat;
            mprod     = exp_prod;
`ifdef MULT_ARB_TIMEOUT_EN
            timed_out = (lat > TO);
`else
            timed_out = 1'b0;
`endif
            exp_done_cyc = start_cyc + (timed_out ? TO : lat) + 1;
        end
        check("grant_id", Grant_Id, m_gid);
        check("mult_a", Mult_A, m_a);
        check("mult_b", Mult_B, m_b);
        busy_now = inflight;
        check("busy", Busy, busy_now);
        exp_done_now = inflight && (cyc == exp_done_cyc);
        check("done", Done, exp_done_now ? (4'b0001 << m_gid) : 4'b0000);
        check("error", Error, exp_done_now && timed_out);
        if (exp_done_now) begin
            m_result  = timed_out ? '0 : exp_prod;
            if (timed_out) mcnt = 0;
            m_last    = m_gid;
            inflight  = 1'b0;
            done_seen = 1'b1;
            done_id   = m_gid;
            done_cyc  = cyc;
        end
        check("result", Result, m_result);
        prev_busy = busy_now;
    endtask

    task automatic tick();
        @(negedge Clock);
        cyc++;
        done_seen = 1'b0;
        mult_step();
        monitor();
    endtask

    task automatic reset_pulse();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    task automatic run_until_done(input int unsigned maxc);
        for (int unsigned i = 0; i < maxc; i++) begin
            tick();
            if (done_seen) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: no Done within %0d cycles (cycle %0d)", maxc, cyc);
    endtask

    task automatic drive_random();
        for (int unsigned i = 0; i < N; i++) begin
            if (done_seen && done_id == i) begin
                if ($urandom_range(0, 3) == 0) begin
                    opa[i] = rand_op();
                    opb[i] = rand_op();
                end else begin
                    Req[i] = 1'b0;
                end
            end else if (Req[i] == 1'b0 && $urandom_range(0, 2) == 0) begin
                opa[i] = rand_op();
                opb[i] = rand_op();
                Req[i] = 1'b1;
            end
        end
        pack_ops();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned order [4];
        int unsigned prev_done;
        logic [2*W-1:0] all4_prod [4];

        vecs[0] = '{req: 4'b0001, a: 32'h0000_000D, b: 32'h0000_000B, lat: 10, exp_id: 0, exp_res: 16'd143};
        vecs[1] = '{req: 4'b1111, a: 32'h0403_02FF, b: 32'h0807_06FF, lat: 3,  exp_id: 0, exp_res: 16'd65025};
        vecs[2] = '{req: 4'b0110, a: 32'h0010_FF00, b: 32'h0010_0200, lat: 1,  exp_id: 1, exp_res: 16'd510};
        vecs[3] = '{req: 4'b1000, a: 32'hC800_0000, b: 32'h0300_0000, lat: 5,  exp_id: 3, exp_res: 16'd600};
        vecs[4] = '{req: 4'b1100, a: 32'h6311_0000, b: 32'h0513_0000, lat: 2,  exp_id: 2, exp_res: 16'd323};
        vecs[5] = '{req: 4'b1010, a: 32'h4000_0000, b: 32'h4000_4D00, lat: 4,  exp_id: 1, exp_res: 16'd0};

        Reset        = 1'b0;
        Req          = '0;
        Op_A         = '0;
        Op_B         = '0;
        Mult_Ready   = 1'b0;
        Mult_Product = '0;
        for (int unsigned i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        mcnt = 0; fixed_lat = 3; rand_lat = 1'b0; spurious_en = 1'b0;
        inflight = 1'b0; prev_busy = 1'b0; timed_out = 1'b0; done_seen = 1'b0;
        m_last = N - 1; m_gid = 0; m_a = '0; m_b = '0; m_result = '0;
        done_id = 0; done_cyc = 0; start_cyc = 0; exp_done_cyc = 0; start_pulses = 0;

        tick();
        tick();
        Reset = 1'b1;

        // Table vectors, each from a fresh reset so requester 0 has priority.
        for (int unsigned v = 0; v < 6; v++) begin
            reset_pulse();
            fixed_lat = vecs[v].lat;
            for (int unsigned i = 0; i < N; i++) begin
                opa[i] = vecs[v].a[i*W +: W];
                opb[i] = vecs[v].b[i*W +: W];
            end
            pack_ops();
            Req = vecs[v].req;
            start_pulses = 0;
            run_until_done(vecs[v].lat + 10);
            check("vec_id", done_id, vecs[v].exp_id);
            check("vec_result", Result, vecs[v].exp_res);
            check("vec_error", Error, 1'b0);
            Req = '0;
            tick();
            tick();
            check("vec_start_pulses", start_pulses, 1);
        end

        // All four requesters at once: served 0,1,2,3.
        reset_pulse();
        fixed_lat = 2;
        opa[0] = 8'd7;   opb[0] = 8'd9;
        opa[1] = 8'd100; opb[1] = 8'd200;
        opa[2] = 8'd12;  opb[2] = 8'd34;
        opa[3] = 8'd255; opb[3] = 8'd255;
        all4_prod[0] = 16'd63;
        all4_prod[1] = 16'd20000;
        all4_prod[2] = 16'd408;
        all4_prod[3] = 16'd65025;
        pack_ops();
        Req = 4'b1111;
        prev_done = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            run_until_done(30);
            order[k] = done_id;
            check("all4_order", order[k], k);
            check("all4_result", Result, all4_prod[k]);
            if (k > 0) check("all4_idle_gap", (done_cyc - prev_done) >= 2, 1'b1);
            prev_done = done_cyc;
            Req[done_id] = 1'b0;
        end
        tick();

        // Requester 2 stays asserted after its Done while 3 joins: 3 goes first.
        reset_pulse();
        fixed_lat = 4;
        opa[2] = 8'd5; opb[2] = 8'd6;
        opa[3] = 8'd9; opb[3] = 8'd9;
        pack_ops();
        Req = 4'b0100;
        run_until_done(30);
        check("rr_first", done_id, 2);
        Req[3] = 1'b1;
        run_until_done(30);
        check("rr_second", done_id, 3);
        check("rr_second_result", Result, 16'd81);
        Req[3] = 1'b0;
        run_until_done(30);
        check("rr_third", done_id, 2);
        check("rr_third_result", Result, 16'd30);
        Req = '0;
        tick();

        // Reset asserted while the multiplier is busy.
        reset_pulse();
        fixed_lat = 10;
        opa[0] = 8'd3; opb[0] = 8'd4;
        pack_ops();
        Req = 4'b0001;
        repeat (4) tick();
        check("midop_busy", Busy, 1'b1);
        Reset = 1'b0;
        Req = 4'b0010;
        opa[1] = 8'd21; opb[1] = 8'd3;
        pack_ops();
        tick();
        check("midop_reset_zero",
              {Done, Result, Error, Busy, Grant_Id, Mult_Start, Mult_A, Mult_B}, 64'd0);
        Reset = 1'b1;
        run_until_done(30);
        check("midop_next_id", done_id, 1);
        check("midop_next_result", Result, 16'd63);
        Req = '0;
        tick();

`ifdef MULT_ARB_TIMEOUT_EN
        // Multiplier never answers: timeout after TO WAIT cycles.
        reset_pulse();
        fixed_lat = 100_000;
        opa[0] = 8'd10; opb[0] = 8'd10;
        pack_ops();
        Req = 4'b0001;
        run_until_done(TO + 20);
        check("to_error", Error, 1'b1);
        check("to_result", Result, 16'd0);
        check("to_latency", done_cyc - start_cyc, TO + 1);
        Req = '0;
        tick();

        // Ready on the last WAIT cycle wins over the timeout.
        reset_pulse();
        fixed_lat = TO;
        opa[1] = 8'd12; opb[1] = 8'd13;
        pack_ops();
        Req = 4'b0010;
        run_until_done(TO + 20);
        check("to_edge_error", Error, 1'b0);
        check("to_edge_result", Result, 16'd156);
        Req = '0;
        tick();
`endif

        // Randomized traffic with variable latency and stray Ready pulses.
        reset_pulse();
        rand_lat    = 1'b1;
        spurious_en = 1'b1;
        for (int unsigned t = 0; t < 3000; t++) begin
            tick();
            drive_random();
        end
        Req = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            tick();
            if (!inflight && i > 2) break;
        end
        check("drain_idle", inflight, 1'b0);
        rand_lat    = 1'b0;
        spurious_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
